rf_issue_seq: RTL

Single-issue instruction sequencer that sits directly upstream of the 32x8 register file. It accepts one ALU instruction at a time over a valid/ready handshake and drives the register file's read and write ports. It sequences read, execute and write-back as a 4-state FSM, so a read and a write never hit the register file on the same edge. It reports each retired result with a one-cycle done pulse.

---
 rtl/rf_issue_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rf_issue_seq.sv
// Single-issue sequencer in front of the 32x8 register file: accepts one ALU
// instruction, then steps it through read, execute and write-back.
module rf_issue_seq #(
  parameter bit WB_R0 = 1'b0,
  localparam int unsigned IDX_W  = 5,
  localparam int unsigned DATA_W = 8,
  localparam int unsigned OP_W   = 3,
  localparam int unsigned EN_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [IDX_W-1:0]  rs1,
  input  logic [IDX_W-1:0]  rs2,
  input  logic [IDX_W-1:0]  rd,
  input  logic [DATA_W-1:0] imm,
  output logic [IDX_W-1:0]  rf_read1,
  output logic [IDX_W-1:0]  rf_read2,
  output logic [IDX_W-1:0]  rf_write,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [EN_W-1:0]   rf_input_valid,
  input  logic [DATA_W-1:0] rf_out1,
  input  logic [DATA_W-1:0] rf_out2,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              done
);

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b101;
  localparam logic [OP_W-1:0] OP_LI   = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP  = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic [OP_W-1:0]     op_q;
  logic [IDX_W-1:0]    rs1_q;
  logic [IDX_W-1:0]    rs2_q;
  logic [IDX_W-1:0]    rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [EN_W-1:0]     port_en;
  logic [DATA_W-1:0]   operand_b;
  logic [DATA_W:0]     sum9;
  logic [DATA_W-1:0]   exec_result;
  logic                exec_carry;

  assign instr_ready    = (state == IDLE) && rst_n;
  assign accept         = instr_valid && instr_ready;
  assign rf_read1       = rs1_q;
  assign rf_read2       = rs2_q;
  assign rf_write       = rd_q;
  assign rf_write_data  = result;
  assign rf_input_valid = port_en;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and register-file port enables
  always_comb begin
    state_next = state;
    port_en    = 3'b000;
    case (state)
      IDLE: begin
        if (accept) begin
          case (opcode)
            OP_LI:   state_next = WRITE;
            OP_NOP:  state_next = IDLE;
            default: state_next = READ;
          endcase
        end
      end
      READ: begin
        port_en    = (op_q == OP_ADDI) ? 3'b100 : 3'b110;
        state_next = EXEC;
      end
      EXEC: state_next = WRITE;
      WRITE: begin
        // r0 write is suppressed unless explicitly enabled; the slot is still spent
        port_en    = ((rd_q != '0) || WB_R0) ? 3'b001 : 3'b000;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU on the register file read data
  always_comb begin
    exec_result = '0;
    exec_carry  = 1'b0;
    operand_b   = (op_q == OP_ADDI) ? imm_q : rf_out2;
    sum9        = {1'b0, rf_out1} + {1'b0, operand_b};
    case (op_q)
      OP_ADD, OP_ADDI: {exec_carry, exec_result} = sum9;
      OP_SUB: begin
        exec_result = rf_out1 - rf_out2;
        exec_carry  = (rf_out1 < rf_out2);
      end
      OP_AND:  exec_result = rf_out1 & rf_out2;
      OP_OR:   exec_result = rf_out1 | rf_out2;
      OP_XOR:  exec_result = rf_out1 ^ rf_out2;
      default: exec_result = '0;
    endcase
  end

  // Latched instruction fields, result/carry and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      result <= '0;
      carry  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q  <= opcode;
        rs1_q <= rs1;
        rs2_q <= rs2;
        rd_q  <= rd;
        imm_q <= imm;
        if (opcode == OP_LI) begin
          result <= imm;
          carry  <= 1'b0;
        end
        if (opcode == OP_NOP) done <= 1'b1;
      end
      if (state == EXEC) begin
        result <= exec_result;
        carry  <= exec_carry;
      end
      if (state == WRITE) done <= 1'b1;
    end
  end

endmodule
